// File: rtl/pc_next_gen.sv
// Next-PC generator and instruction-fetch handshake controller. The PC register
// itself has no enable or reset, so every hold and the reset vector come from here.
module pc_next_gen #(
  parameter int unsigned       WORD         = 32,
  parameter logic [WORD-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [WORD-1:0]   EXC_VECTOR   = 32'h8000_0180
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WORD-1:0] curr,
  output logic [WORD-1:0] next,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [WORD-1:0] br_target,
  input  logic            j_valid,
  input  logic [WORD-1:0] j_target,
  input  logic            exc,
  output logic            flush_ifid,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait} state_e;

  state_e          state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  logic [1:0]      pend_prio_q, pend_prio_d;
  logic [WORD-1:0] pend_target_q, pend_target_d;
  logic [31:0]     count_q, count_d;

  logic            new_valid, new_wins, fetch_done, redirect, flush;
  logic [1:0]      new_prio;
  logic [WORD-1:0] new_target, next_raw;

  always_comb begin
    new_valid = exc | br_taken | j_valid;
    // Priority encoding: exc=3 > branch=2 > jump=1; branch is the older instruction.
    if (exc) begin
      new_prio   = 2'd3;
      new_target = EXC_VECTOR;
    end else if (br_taken) begin
      new_prio   = 2'd2;
      new_target = br_target;
    end else if (j_valid) begin
      new_prio   = 2'd1;
      new_target = j_target;
    end else begin
      new_prio   = 2'd0;
      new_target = '0;
    end
    // Ties go to the newer redirect.
    new_wins   = new_valid && (!pend_valid_q || (new_prio >= pend_prio_q));
    fetch_done = (state_q != StIdle) && imem_ready;
    redirect   = fetch_done && (new_valid || pend_valid_q);

    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_prio_d   = pend_prio_q;
    pend_target_d = pend_target_q;
    count_d       = count_q;
    next_raw      = curr;
    flush         = 1'b0;

    unique case (state_q)
      StIdle: begin
        next_raw = RESET_VECTOR;
        state_d  = StFetch;
      end
      StFetch, StWait: state_d = imem_ready ? StFetch : StWait;
      default:         state_d = StIdle;
    endcase

    if (fetch_done) begin
      if (redirect) begin
        next_raw     = new_wins ? new_target : pend_target_q;
        flush        = 1'b1;
        pend_valid_d = 1'b0;
      end else if (stall) begin
        next_raw = curr;
      end else begin
        next_raw = curr + WORD'(4);
        count_d  = count_q + 32'd1;
      end
    end else if ((state_q != StIdle) && new_wins) begin
      pend_valid_d  = 1'b1;
      pend_prio_d   = new_prio;
      pend_target_d = new_target;
    end
  end

  assign next        = {next_raw[WORD-1:2], 2'b00};
  assign imem_req    = (state_q != StIdle);
  assign flush_ifid  = flush;
  assign fetch_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pend_valid_q  <= 1'b0;
      pend_prio_q   <= 2'd0;
      pend_target_q <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_prio_q   <= pend_prio_d;
      pend_target_q <= pend_target_d;
      count_q       <= count_d;
    end
  end

endmodule
